// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and dmem_responder.
// The initiator drives the request fields and rsp_ready; the responder
// drives req_ready and the response fields.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Handshaked data-memory slave with programmable wait states.
// One request is captured in IDLE, held for LATENCY cycles in WAIT, the
// access is performed on the WAIT->RESP edge, and the response is held in
// RESP until the initiator takes it. No overlap between transactions.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_W32 = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      offset;
    logic             acc_err;
    logic [IDX_W-1:0] idx;
    logic             mem_we;

    // Decode the captured address into a word index and a fault flag.
    always_comb begin
        offset  = addr_q - BASE_ADDR;
        acc_err = (addr_q[1:0] != 2'b00) ||
                  (addr_q < BASE_ADDR)   ||
                  ((offset >> 2) >= DEPTH_W32);
        idx     = offset[IDX_W+1:2];
    end

    // Next-state and next-output logic of the IDLE/WAIT/RESP controller.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        mem_we      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d        = bus.req_we;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    be_d        = bus.req_be;
                    cnt_d       = 4'(LATENCY);
                    req_ready_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end

            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access happens on this edge; a write commits here so
                    // any later read observes it.
                    mem_we      = we_q && !acc_err;
                    rdata_d     = (!we_q && !acc_err) ? mem[idx] : 32'h0;
                    err_d       = acc_err;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end

            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    rdata_d     = 32'h0;
                    err_d       = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d     = S_IDLE;
                cnt_d       = 4'd0;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rdata_d     = 32'h0;
                err_d       = 1'b0;
            end
        endcase
    end

    // Controller state, captured request and registered response.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Byte-masked write into the backing array.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto plain RAM; contents survive reset.
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, scoreboarded bench for dmem_responder: one instance with
// LATENCY=2 for functional/latency/backpressure/reset checks and one with
// LATENCY=0 for back-to-back throughput.
module tb_dmem_responder;

    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

    typedef struct {
        logic        we;
        int          idx;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    logic [31:0] model_a [64];
    exp_t        sb_a[$];
    exp_t        sb_b[$];

    dmem_responder_if a_if ();
    dmem_responder_if b_if ();

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(LAT_A), .BASE_ADDR(32'h0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if)
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(LAT_B), .BASE_ADDR(32'h0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    // 64 words at base 0 cover byte addresses 0x00..0xFF.
    function automatic logic model_err(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr >= 32'h100);
    endfunction

    // One full transaction on the LATENCY=2 instance, with `stall` cycles
    // of rsp_ready=0 while the response is presented.
    task automatic req_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int stall);
        exp_t e;
        int   edges;
        @(negedge clk);
        check("a_ready_idle", 32'(a_if.req_ready), 32'd1);
        e.we    = we;
        e.idx   = int'(addr[7:2]);
        e.wdata = wdata;
        e.be    = be;
        e.err   = model_err(addr);
        e.rdata = (we || e.err) ? 32'h0 : model_a[e.idx];
        sb_a.push_back(e);
        a_if.req_valid = 1'b1;
        a_if.req_we    = we;
        a_if.req_addr  = addr;
        a_if.req_wdata = wdata;
        a_if.req_be    = be;
        @(posedge clk);
        @(negedge clk);
        // Scramble the request bus and toggle rsp_ready outside RESP.
        a_if.req_valid = 1'b0;
        a_if.req_we    = 1'($urandom);
        a_if.req_addr  = $urandom;
        a_if.req_wdata = $urandom;
        a_if.req_be    = 4'($urandom);
        a_if.rsp_ready = 1'($urandom);
        check("a_ready_busy", 32'(a_if.req_ready), 32'd0);
        edges = 0;
        while (a_if.rsp_valid !== 1'b1 && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        a_if.rsp_ready = 1'b0;
        check("a_latency", 32'(edges), 32'(LAT_A + 1));
        check("a_ready_resp", 32'(a_if.req_ready), 32'd0);
        e = sb_a.pop_front();
        check("a_rdata", a_if.rsp_rdata, e.rdata);
        check("a_err", 32'(a_if.rsp_err), 32'(e.err));
        if (e.we && !e.err) begin
            for (int b = 0; b < 4; b++)
                if (e.be[b]) model_a[e.idx][8*b +: 8] = e.wdata[8*b +: 8];
        end
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", 32'(a_if.rsp_valid), 32'd1);
            check("bp_rdata", a_if.rsp_rdata, e.rdata);
            check("bp_err", 32'(a_if.rsp_err), 32'(e.err));
            check("bp_ready", 32'(a_if.req_ready), 32'd0);
        end
        a_if.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_if.rsp_ready = 1'b0;
        check("a_done_valid", 32'(a_if.rsp_valid), 32'd0);
        check("a_done_ready", 32'(a_if.req_ready), 32'd1);
        check("a_done_rdata", a_if.rsp_rdata, 32'h0);
        check("a_done_err", 32'(a_if.rsp_err), 32'd0);
    endtask

    initial begin
        exp_t        e;
        int          edges;
        int          acc;
        int          prev_acc;
        int          waited;
        logic        b_we    [4];
        logic [31:0] b_addr  [4];
        logic [31:0] b_wdata [4];
        logic [31:0] b_rdata [4];

        a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = 32'h0;
        a_if.req_wdata = 32'h0; a_if.req_be = 4'h0; a_if.rsp_ready = 1'b0;
        b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_addr = 32'h0;
        b_if.req_wdata = 32'h0; b_if.req_be = 4'h0; b_if.rsp_ready = 1'b0;

        // Reset values while reset is held.
        #12;
        check("rst_a_ready", 32'(a_if.req_ready), 32'd1);
        check("rst_a_valid", 32'(a_if.rsp_valid), 32'd0);
        check("rst_a_rdata", a_if.rsp_rdata, 32'h0);
        check("rst_a_err", 32'(a_if.rsp_err), 32'd0);
        check("rst_b_ready", 32'(b_if.req_ready), 32'd1);
        check("rst_b_valid", 32'(b_if.rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Give every word a known value.
        for (int i = 0; i < 64; i++)
            req_a(1'b1, 32'(i * 4), 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203), 4'hF, 0);

        // Full-word write then read back.
        req_a(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        req_a(1'b0, 32'h10, 32'h0, 4'h0, 0);

        // Byte-masked write: expect 0x11BB33DD.
        req_a(1'b1, 32'h20, 32'h1122_3344, 4'hF, 0);
        req_a(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0);
        req_a(1'b0, 32'h20, 32'h0, 4'hF, 0);

        // be=0 write is a no-op that still responds.
        req_a(1'b1, 32'h24, 32'hFFFF_FFFF, 4'h0, 0);
        req_a(1'b0, 32'h24, 32'h0, 4'h0, 0);

        // Faults: misaligned, out of range, last valid word.
        req_a(1'b0, 32'h13, 32'h0, 4'hF, 0);
        req_a(1'b0, 32'h100, 32'h0, 4'hF, 0);
        req_a(1'b1, 32'h100, 32'h0BAD_0BAD, 4'hF, 0);
        req_a(1'b0, 32'hFC, 32'h0, 4'hF, 0);

        // Backpressure: 5 cycles of rsp_ready=0 on a read.
        req_a(1'b0, 32'h10, 32'h0, 4'hF, 5);

        // Reset in the middle of a write's WAIT: write is dropped.
        req_a(1'b1, 32'h30, 32'h0, 4'hF, 0);
        @(negedge clk);
        a_if.req_valid = 1'b1;
        a_if.req_we    = 1'b1;
        a_if.req_addr  = 32'h30;
        a_if.req_wdata = 32'hFFFF_FFFF;
        a_if.req_be    = 4'hF;
        @(posedge clk);
        #2;
        check("mid_wait_busy", 32'(a_if.req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_ready", 32'(a_if.req_ready), 32'd1);
        check("mid_rst_valid", 32'(a_if.rsp_valid), 32'd0);
        check("mid_rst_rdata", a_if.rsp_rdata, 32'h0);
        check("mid_rst_err", 32'(a_if.rsp_err), 32'd0);
        a_if.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        req_a(1'b0, 32'h30, 32'h0, 4'hF, 0);

        // Every word intact after the faulted write and the dropped one.
        for (int i = 0; i < 64; i++)
            req_a(1'b0, 32'(i * 4), 32'h0, 4'hF, 0);

        // LATENCY=0 instance: back-to-back with rsp_ready held high.
        b_we[0] = 1'b1; b_addr[0] = 32'h08; b_wdata[0] = 32'hCAFE_F00D; b_rdata[0] = 32'h0;
        b_we[1] = 1'b1; b_addr[1] = 32'h0C; b_wdata[1] = 32'h0BAD_F00D; b_rdata[1] = 32'h0;
        b_we[2] = 1'b0; b_addr[2] = 32'h08; b_wdata[2] = 32'h0;         b_rdata[2] = 32'hCAFE_F00D;
        b_we[3] = 1'b0; b_addr[3] = 32'h0C; b_wdata[3] = 32'h0;         b_rdata[3] = 32'h0BAD_F00D;
        @(negedge clk);
        b_if.rsp_ready = 1'b1;
        prev_acc = 0;
        for (int k = 0; k < 4; k++) begin
            b_if.req_valid = 1'b1;
            b_if.req_we    = b_we[k];
            b_if.req_addr  = b_addr[k];
            b_if.req_wdata = b_wdata[k];
            b_if.req_be    = 4'hF;
            e.we = b_we[k]; e.idx = 0; e.wdata = b_wdata[k]; e.be = 4'hF;
            e.err = 1'b0; e.rdata = b_rdata[k];
            sb_b.push_back(e);
            waited = 0;
            while (b_if.req_ready !== 1'b1 && waited < 20) begin
                @(posedge clk);
                @(negedge clk);
                waited++;
            end
            check("b_ready_idle", 32'(b_if.req_ready), 32'd1);
            acc = cyc + 1;
            if (k > 0) check("b_spacing", 32'(acc - prev_acc), 32'd3);
            prev_acc = acc;
            @(posedge clk);
            @(negedge clk);
            if (k < 3) begin
                // Next request presented early; must wait for IDLE.
                b_if.req_we    = b_we[k+1];
                b_if.req_addr  = b_addr[k+1];
                b_if.req_wdata = b_wdata[k+1];
            end else begin
                b_if.req_valid = 1'b0;
            end
            check("b_ready_busy", 32'(b_if.req_ready), 32'd0);
            edges = 0;
            while (b_if.rsp_valid !== 1'b1 && edges < 20) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
            check("b_latency", 32'(edges), 32'(LAT_B + 1));
            e = sb_b.pop_front();
            check("b_rdata", b_if.rsp_rdata, e.rdata);
            check("b_err", 32'(b_if.rsp_err), 32'(e.err));
            @(posedge clk);
            @(negedge clk);
            check("b_done_valid", 32'(b_if.rsp_valid), 32'd0);
        end
        b_if.rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
